mem_arb: RTL
============

# mem_arb

Single-port SRAM arbiter that lets the core's instruction-fetch port and data port share one 64 KB word-wide SRAM (four byte lanes, 14-bit word address, 1-cycle read latency). It sits between `core` and the SRAM macro/model and grants at most one access per cycle. Data accesses take priority, bounded by a starvation counter that guarantees fetch progress. Read data is routed back to the port that issued it and held stable until that port's next read completes.

## Interface
Parameters:
- `AW`, 16: byte-address width of both core ports; the SRAM word address is `[AW-1:2]`.
- `MAX_DAT_RUN`, 4: maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ins_a` in AW: fetch byte address; bits [1:0] are ignored.
- `ins_e` in 1: fetch request.
- `ins_gnt` out 1: fetch accepted this cycle.
- `ins_vld` out 1: `ins` carries new fetch data this cycle.
- `ins` out 32: fetch read data.
- `dat_a` in AW: data byte address; bits [1:0] are ignored.
- `dat_re` in 1: data read request.
- `dat_we` in 1: data write request.
- `dat_be` in 4: byte enables for writes; bit i selects lane [8i+:8].
- `dat_wd` in 32: write data.
- `dat_gnt` out 1: data access accepted this cycle.
- `dat_vld` out 1: `dat_rd` carries new read data this cycle.
- `dat_rd` out 32: data read data.
- `sram_e` out 1: SRAM access enable.
- `sram_we` out 4: per-lane write enables.
- `sram_a` out AW-2: SRAM word address.
- `sram_wd` out 32: SRAM write data.
- `sram_rd` in 32: SRAM read data, valid the cycle after a read with `sram_e`=1 and `sram_we`=0.

## Operation
- Grants are combinational from the requests and the registered arbiter state. A request is accepted in the cycle its grant is high. The requester holds its address and controls until it is granted.
- The data port requests when `dat_re | dat_we` is high.
- If `dat_we` is set, the access is a write: `sram_we` = `dat_be`, and `dat_re` is ignored. A write with `dat_be`=0 is still granted and consumes the slot, but no lane is written.
- **Arbiter states:**
  - `DAT_PRI` (reset state): data wins a conflict.
  - `INS_PRI`: fetch wins a conflict.
- **Starvation counter** `run_cnt` (4 bits, reset 0):
  - Increments on each data grant while `ins_e` is high. Resets to 0 on any fetch grant.
  - Transition `DAT_PRI`→`INS_PRI` when a data grant makes `run_cnt` reach `MAX_DAT_RUN`.
  - Transition `INS_PRI`→`DAT_PRI` on the next fetch grant.
- A lone requester is always granted, whatever the state.
- **SRAM drive:** `sram_e` = `ins_gnt | dat_gnt`. Address, write data and write enables come from the granted port.
- **Read return:**
  - A 1-bit `rd_owner` register and a `rd_pend` register record the owner of each granted read.
  - In the following cycle, `sram_rd` is steered to that port and its `*_vld` is pulsed.
  - Writes produce no `*_vld`.
- **Output hold:**
  - `ins` and `dat_rd` equal `sram_rd` during their vld cycle. At all other times each shows its own hold register, which captures `sram_rd` at the end of the vld cycle.
  - Each port therefore keeps its last read value while the other port uses the SRAM.
- **Reset:** applies in the cycle `rst` is high. A read granted in the cycle before reset never produces a `*_vld`.

## Timing
- Request to grant: 0 cycles when uncontended. A contended fetch waits at most `MAX_DAT_RUN` data grants.
- Read grant in cycle N → `*_vld` and data in cycle N+1. Back-to-back reads give one result per cycle.
- A write granted in cycle N is visible to a read granted in cycle N+1.
- Reset values:
  - `ins_gnt`, `dat_gnt`, `ins_vld`, `dat_vld`, `sram_e`, `sram_we` all 0.
  - `ins`, `dat_rd` hold registers = 0.
  - `sram_a`, `sram_wd` = 0.
  - State `DAT_PRI`, `run_cnt` = 0, `rd_pend` = 0.
- While `rst` is high, all grants are forced to 0.

## Structure
- Shared package `mem_pkg`:
  - `SRAM_AW` = 14.
  - `arb_state_e` {`DAT_PRI`, `INS_PRI`}.
  - `port_e` {`PORT_INS`, `PORT_DAT`}.
- One sub-module, `mem_rd_hold`: the per-port hold register plus output mux, instantiated twice.

## Test plan
- Reset, then fetch-only reads at 0x0000, 0x0004, 0x0008 → `ins_gnt`=1 every cycle; `ins_vld` with `ins` = the matching SRAM words one cycle later; `dat_vld` stays 0.
- Write `dat_a`=0x0100, `dat_be`=4'b0101, `dat_wd`=0xAABBCCDD over an initial word of 0x11223344, then read 0x0100 → `dat_rd`=0x11BB33DD.
- Fetch and data read both held high continuously with `MAX_DAT_RUN`=4 → grant pattern D,D,D,D,I repeating. `ins_vld` appears exactly once per 5 cycles.
- Fetch read of 0x0010 (word 0xDEADBEEF), then 3 data reads → `ins` stays 0xDEADBEEF throughout.
- Assert `rst` in the cycle after a data read grant → no `dat_vld`; all outputs 0 and state `DAT_PRI` on the next cycle.
- Byte address 0x0103 → `sram_a`=0x040; low bits ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the fetch/data SRAM arbiter: arbiter priority state and read-owner tag.
package mem_pkg;
    localparam int SRAM_AW = 14;

    typedef enum logic {DAT_PRI, INS_PRI} arb_state_e;
    typedef enum logic {PORT_INS, PORT_DAT} port_e;
endpackage

// File: rtl/mem_rd_hold.sv
// Per-port read-data hold: passes SRAM data through in the valid cycle, otherwise shows the last read.
module mem_rd_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_i,
    input  logic [31:0] rd_i,
    output logic [31:0] dout_o
);
    logic [31:0] hold_q;
    logic [31:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (vld_i) hold_d = rd_i;
    end

    always_ff @(posedge clk) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end

    assign dout_o = vld_i ? rd_i : hold_q;
endmodule

// File: rtl/mem_arb.sv
// Single-port SRAM arbiter for the core's fetch and data ports; data has priority,
// bounded by a run counter that hands priority to a waiting fetch.
//
// Handshake: a port's request is accepted in any cycle its *_gnt is high; the port
// holds address/controls stable until then. Read data returns one cycle after grant
// with a one-cycle *_vld pulse; writes return nothing.
module mem_arb
    import mem_pkg::*;
#(
    parameter int AW          = 16,
    parameter int MAX_DAT_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ins_a,
    input  logic          ins_e,
    output logic          ins_gnt,
    output logic          ins_vld,
    output logic [31:0]   ins,
    input  logic [AW-1:0] dat_a,
    input  logic          dat_re,
    input  logic          dat_we,
    input  logic [3:0]    dat_be,
    input  logic [31:0]   dat_wd,
    output logic          dat_gnt,
    output logic          dat_vld,
    output logic [31:0]   dat_rd,
    output logic          sram_e,
    output logic [3:0]    sram_we,
    output logic [AW-3:0] sram_a,
    output logic [31:0]   sram_wd,
    input  logic [31:0]   sram_rd,
    output arb_state_e    dbg_state
);
    localparam logic [3:0] MAX_RUN = 4'(MAX_DAT_RUN);

    arb_state_e  state_q, state_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    port_e       rd_owner_q, rd_owner_d;
    logic        dat_req;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{ins_a[1:0], dat_a[1:0]};

    always_comb begin
        dat_req = dat_re | dat_we;
        ins_gnt = !rst && ins_e && (!dat_req || state_q == INS_PRI);
        dat_gnt = !rst && dat_req && (!ins_e || state_q == DAT_PRI);
    end

    // Only contended data grants count toward starvation; any fetch grant clears it.
    always_comb begin
        run_cnt_d  = run_cnt_q;
        state_d    = state_q;
        rd_pend_d  = ins_gnt || (dat_gnt && !dat_we);
        rd_owner_d = dat_gnt ? PORT_DAT : PORT_INS;
        if (ins_gnt) begin
            run_cnt_d = '0;
            state_d   = DAT_PRI;
        end else if (dat_gnt && ins_e) begin
            run_cnt_d = run_cnt_q + 4'd1;
            if (state_q == DAT_PRI && run_cnt_d == MAX_RUN) state_d = INS_PRI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DAT_PRI;
            run_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT_INS;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        sram_e  = ins_gnt | dat_gnt;
        sram_a  = '0;
        sram_we = '0;
        sram_wd = '0;
        if (dat_gnt) begin
            sram_a  = dat_a[AW-1:2];
            sram_we = dat_we ? dat_be : 4'b0000;
            sram_wd = dat_wd;
        end else if (ins_gnt) begin
            sram_a  = ins_a[AW-1:2];
        end
    end

    // A read granted just before reset is dropped by gating vld with rst.
    assign ins_vld   = !rst && rd_pend_q && (rd_owner_q == PORT_INS);
    assign dat_vld   = !rst && rd_pend_q && (rd_owner_q == PORT_DAT);
    assign dbg_state = state_q;

    mem_rd_hold u_ins_hold (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (ins_vld),
        .rd_i   (sram_rd),
        .dout_o (ins)
    );

    mem_rd_hold u_dat_hold (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (dat_vld),
        .rd_i   (sram_rd),
        .dout_o (dat_rd)
    );
endmodule
